// File: rtl/sub_drain_pkg.sv
// Shared types and widths for the sub_drain countdown block.
package sub_drain_pkg;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned TOT_W = 10;
  localparam logic [CNT_W-1:0] LIMIT_NUM_DEF = 6'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sub_drain_round_ctr.sv
// In-round unit counter and completed-round counter for sub_drain.
module sub_drain_round_ctr
  import sub_drain_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT_NUM = LIMIT_NUM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             restart,
  input  logic             step,
  input  logic             end_round,
  input  logic [CNT_W-1:0] max_num,
  output logic [CNT_W-1:0] now_num,
  output logic [CNT_W-1:0] flag,
  output logic             round_end,
  output logic             limit_hit
);

  // A round is over once its quota is used or the round budget is spent.
  always_comb begin
    round_end = !((now_num < max_num) && (flag < LIMIT_NUM));
    limit_hit = (flag + CNT_W'(1)) == LIMIT_NUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_num <= '0;
      flag    <= '0;
    end else if (clear) begin
      now_num <= '0;
      flag    <= '0;
    end else if (restart) begin
      now_num <= '0;
    end else if (end_round) begin
      now_num <= '0;
      flag    <= flag + CNT_W'(1);
    end else if (step) begin
      now_num <= now_num + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sub_drain.sv
// Countdown drain of a loaded total in bounded rounds.
// Optional round_done pulse output is enabled by SUB_DRAIN_ROUND_PULSE_EN.
module sub_drain
  import sub_drain_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT_NUM = LIMIT_NUM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             control,
  input  logic             judge,
  input  logic             load,
  input  logic [TOT_W-1:0] load_num,
  input  logic [CNT_W-1:0] max_num,
  output logic [TOT_W-1:0] left_num,
  output logic [CNT_W-1:0] now_num,
  output logic [CNT_W-1:0] flag,
  output logic             busy,
  output logic             done,
`ifdef SUB_DRAIN_ROUND_PULSE_EN
  output logic             round_done,
`endif
  output logic             empty
);

  state_t state, nxt;
  logic   accept, clr, restart, step, end_round, running;
  logic   round_end, limit_hit;

  // Control decode; clear (control low) wins over everything but rst.
  always_comb begin
    running   = (state == ST_RUN) && judge;
    accept    = control && load && ((state == ST_IDLE) || (state == ST_DONE));
    clr       = !control || accept;
    restart   = control && !judge && ((state == ST_RUN) || (state == ST_PAUSE));
    step      = control && running && !round_end;
    end_round = control && running && round_end;
    nxt       = state;
    if (!control) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (load) nxt = (load_num == '0) ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (!judge)                                  nxt = ST_PAUSE;
          else if (step && (left_num == TOT_W'(1)))    nxt = ST_DONE;
          else if (end_round && limit_hit)             nxt = ST_DONE;
        end
        ST_PAUSE: if (judge) nxt = ST_RUN;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      left_num <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= (nxt == ST_RUN) || (nxt == ST_PAUSE);
      done  <= (nxt == ST_DONE);
      if (!control)  left_num <= '0;
      else if (accept) left_num <= load_num;
      else if (step)   left_num <= left_num - TOT_W'(1);
    end
  end

`ifdef SUB_DRAIN_ROUND_PULSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) round_done <= 1'b0;
    else     round_done <= end_round;
  end
`endif

  assign empty = (left_num == '0);

  sub_drain_round_ctr #(.LIMIT_NUM(LIMIT_NUM)) u_round_ctr (
    .clk       (clk),
    .rst       (rst),
    .clear     (clr),
    .restart   (restart),
    .step      (step),
    .end_round (end_round),
    .max_num   (max_num),
    .now_num   (now_num),
    .flag      (flag),
    .round_end (round_end),
    .limit_hit (limit_hit)
  );

endmodule

// File: tb/tb_sub_drain.sv
// Self-checking bench for sub_drain: rule-level model plus directed scenarios.
module tb_sub_drain;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       control = 1'b1;
  logic       judge = 1'b0;
  logic       load = 1'b0;
  logic [9:0] load_num = '0;
  logic [5:0] max_num = '0;
  logic [9:0] left_num;
  logic [5:0] now_num, flag;
  logic       busy, done, empty;
`ifdef SUB_DRAIN_ROUND_PULSE_EN
  logic       round_done;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: balances as integers, activity as plain flags.
  int m_left = 0, m_now = 0, m_flag = 0;
  bit m_run = 0, m_pause = 0, m_done = 0, m_rd = 0;

  always #5 clk = ~clk;

  sub_drain dut (
    .clk        (clk),
    .rst        (rst),
    .control    (control),
    .judge      (judge),
    .load       (load),
    .load_num   (load_num),
    .max_num    (max_num),
    .left_num   (left_num),
    .now_num    (now_num),
    .flag       (flag),
    .busy       (busy),
    .done       (done),
`ifdef SUB_DRAIN_ROUND_PULSE_EN
    .round_done (round_done),
`endif
    .empty      (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_left = 0; m_now = 0; m_flag = 0;
    m_run = 0; m_pause = 0; m_done = 0; m_rd = 0;
  endtask

  always @(posedge rst) model_clear();

  always @(posedge clk) begin
    m_rd = 0;
    if (rst || !control) begin
      model_clear();
    end else if (!m_run && !m_pause) begin
      if (load) begin
        m_left = int'(load_num); m_now = 0; m_flag = 0;
        m_done = (load_num == 0);
        m_run  = (load_num != 0);
      end
    end else if (!judge) begin
      m_run = 0; m_pause = 1; m_now = 0;
    end else if (m_pause) begin
      m_pause = 0; m_run = 1;
    end else if (m_now < int'(max_num) && m_flag < LIMIT) begin
      m_left--; m_now++;
      if (m_left == 0) begin m_run = 0; m_done = 1; end
    end else begin
      m_now = 0; m_flag++; m_rd = 1;
      if (m_flag == LIMIT) begin m_run = 0; m_done = 1; end
    end
  end

  // Per-cycle comparison, sampled mid-cycle away from the clock edge.
  always @(posedge clk) begin
    #3;
    check("left_num", 32'(left_num), 32'(m_left));
    check("now_num", 32'(now_num), 32'(m_now));
    check("flag", 32'(flag), 32'(m_flag));
    check("busy", 32'(busy), 32'(m_run || m_pause));
    check("done", 32'(done), 32'(m_done));
    check("empty", 32'(empty), 32'(m_left == 0));
`ifdef SUB_DRAIN_ROUND_PULSE_EN
    check("round_done", 32'(round_done), 32'(m_rd));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_go(input int n, input int m);
    load_num = 10'(n);
    max_num  = 6'(m);
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n, output int rd);
    n = 0;
    rd = 0;
    while (n < bound) begin
      tick();
      n++;
`ifdef SUB_DRAIN_ROUND_PULSE_EN
      rd += int'(round_done);
`endif
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int n, rd;
    repeat (2) @(posedge clk);
    #1;
    check("rst_left", 32'(left_num), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    rst   = 1'b0;
    judge = 1'b1;
    tick();

    // Exhaust by balance
    load_go(10, 3);
    wait_done(40, n, rd);
    check("bal_cycles", 32'(n), 32'd13);
    check("bal_left", 32'(left_num), 32'd0);
    check("bal_flag", 32'(flag), 32'd3);
    check("bal_now", 32'(now_num), 32'd1);
`ifdef SUB_DRAIN_ROUND_PULSE_EN
    check("bal_pulses", 32'(rd), 32'd3);
`endif

    // Exhaust by round limit, loaded straight from DONE
    load_go(100, 5);
    wait_done(60, n, rd);
    check("lim_cycles", 32'(n), 32'd24);
    check("lim_left", 32'(left_num), 32'd80);
    check("lim_flag", 32'(flag), 32'd4);
    check("lim_empty", 32'(empty), 32'd0);

    // Pause mid-round
    load_go(20, 5);
    tick(); tick();
    check("pre_pause_now", 32'(now_num), 32'd2);
    judge = 1'b0;
    repeat (3) tick();
    check("pause_now", 32'(now_num), 32'd0);
    check("pause_left", 32'(left_num), 32'd18);
    check("pause_flag", 32'(flag), 32'd0);
    judge = 1'b1;
    tick();
    check("resume_idle_left", 32'(left_num), 32'd18);
    tick();
    check("resume_left", 32'(left_num), 32'd17);

    // Clear together with load
    control = 1'b0;
    load_go(5, 3);
    control = 1'b1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_left", 32'(left_num), 32'd0);
    tick();
    check("clr_stays_idle", 32'(busy), 32'd0);

    // Zero total
    load_go(0, 3);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);

    // Zero quota
    load_go(7, 0);
    wait_done(20, n, rd);
    check("q0_cycles", 32'(n), 32'd4);
    check("q0_left", 32'(left_num), 32'd7);

    // Load during RUN is ignored
    load_go(30, 5);
    tick(); tick();
    load_num = 10'd99;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    check("run_load_left", 32'(left_num), 32'd27);
    check("run_load_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-round
    tick();
    rst = 1'b1;
    #1;
    check("arst_left", 32'(left_num), 32'd0);
    check("arst_now", 32'(now_num), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
